// File: rtl/toy_stream_pkg.sv
// Shared types and helpers for the toy stream checker and its pattern generator.
package toy_stream_pkg;

  localparam int LANE_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of 32-bit lanes packed into one stream word.
  function automatic int lane_count(input int data_width);
    return data_width / LANE_W;
  endfunction

endpackage

// File: rtl/toy_stream_checker_pattern.sv
// Combinational lane-pattern generator: lane i of word n is
// seed + n*L + i (+1 when building the expected kernel result), 32-bit wrapping per lane.
module toy_lane_pattern
  import toy_stream_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 512,
  parameter int C_COUNT_WIDTH = 32
) (
  input  logic [31:0]              seed_i,
  input  logic [C_COUNT_WIDTH-1:0] index_i,
  input  logic                     add_one_i,
  output logic [C_DATA_WIDTH-1:0]  word_o
);

  localparam int L = lane_count(C_DATA_WIDTH);

  logic [C_COUNT_WIDTH-1:0] base_full;
  logic [31:0]              base32;

  // n*L is formed at counter width and only then reduced to lane width.
  assign base_full = index_i * C_COUNT_WIDTH'(L);
  assign base32    = 32'(base_full);

  for (genvar g = 0; g < L; g++) begin : g_lane
    assign word_o[g*LANE_W +: LANE_W] = seed_i + base32 + 32'(g) + {31'd0, add_one_i};
  end

endmodule

// File: rtl/toy_stream_checker.sv
// Traffic source/sink for the toy kernel: drives a deterministic word stream into
// the kernel input, accepts the kernel output and counts words whose lanes are not input+1.
module toy_stream_checker
  import toy_stream_pkg::*;
#(
  parameter int C_DATA_WIDTH  = 512,
  parameter int C_COUNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [C_COUNT_WIDTH-1:0] num_words,
  input  logic [31:0]              seed,
  output logic                     busy,
  output logic                     done,
  output logic [C_COUNT_WIDTH-1:0] err_count,
  output logic [C_COUNT_WIDTH-1:0] first_err_idx,
  output logic                     k_in_avail,
  input  logic                     k_in_ready,
  output logic [C_DATA_WIDTH-1:0]  k_in_data,
  input  logic                     k_out_avail,
  output logic                     k_out_ready,
  input  logic [C_DATA_WIDTH-1:0]  k_out_data
);

  localparam logic [C_COUNT_WIDTH-1:0] CNT_ONE = C_COUNT_WIDTH'(1);
  localparam logic [C_COUNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                   state_q, state_d;
  logic [C_COUNT_WIDTH-1:0] num_words_q, num_words_d;
  logic [31:0]              seed_q, seed_d;
  logic [C_COUNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
  logic [C_COUNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
  logic [C_COUNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [C_COUNT_WIDTH-1:0] first_err_q, first_err_d;
  logic                     k_in_avail_q, k_in_avail_d;
  logic [C_DATA_WIDTH-1:0]  k_in_data_q, k_in_data_d;

  logic [31:0]              tx_seed;
  logic [C_COUNT_WIDTH-1:0] tx_idx;
  logic [C_DATA_WIDTH-1:0]  tx_word;
  logic [C_DATA_WIDTH-1:0]  exp_word;
  logic                     rx_ready;
  logic                     tx_fire;
  logic                     rx_fire;
  logic                     rx_mismatch;

  // In IDLE the generator builds word 0 from the live seed so it can load on the start edge;
  // in RUN it pre-computes the word following the one currently offered.
  assign tx_seed = (state_q == IDLE) ? seed : seed_q;
  assign tx_idx  = (state_q == IDLE) ? '0 : tx_cnt_q + CNT_ONE;

  toy_lane_pattern #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_COUNT_WIDTH(C_COUNT_WIDTH)
  ) u_tx_pattern (
    .seed_i   (tx_seed),
    .index_i  (tx_idx),
    .add_one_i(1'b0),
    .word_o   (tx_word)
  );

  toy_lane_pattern #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_COUNT_WIDTH(C_COUNT_WIDTH)
  ) u_exp_pattern (
    .seed_i   (seed_q),
    .index_i  (rx_cnt_q),
    .add_one_i(1'b1),
    .word_o   (exp_word)
  );

  assign rx_ready    = (state_q == RUN) && (rx_cnt_q < num_words_q);
  assign tx_fire     = k_in_avail_q && k_in_ready;
  assign rx_fire     = k_out_avail && rx_ready;
  assign rx_mismatch = (k_out_data != exp_word);

  // Next-state: FSM sequencing plus independent transmit and receive bookkeeping.
  always_comb begin
    state_d      = state_q;
    num_words_d  = num_words_q;
    seed_d       = seed_q;
    tx_cnt_d     = tx_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    err_count_d  = err_count_q;
    first_err_d  = first_err_q;
    k_in_avail_d = k_in_avail_q;
    k_in_data_d  = k_in_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_words_d = num_words;
          seed_d      = seed;
          tx_cnt_d    = '0;
          rx_cnt_d    = '0;
          err_count_d = '0;
          first_err_d = '0;
          if (num_words == '0) begin
            state_d      = DONE;
            k_in_avail_d = 1'b0;
          end else begin
            state_d      = RUN;
            k_in_avail_d = 1'b1;
            k_in_data_d  = tx_word;
          end
        end
      end

      RUN: begin
        if (tx_fire) begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
          if (tx_cnt_q + CNT_ONE == num_words_q) begin
            k_in_avail_d = 1'b0;
          end else begin
            k_in_data_d = tx_word;
          end
        end
        if (rx_fire) begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
          if (rx_mismatch) begin
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + CNT_ONE;
            end
            if (err_count_q == '0) begin
              first_err_d = rx_cnt_q;
            end
          end
          if (rx_cnt_q + CNT_ONE == num_words_q) begin
            state_d      = DONE;
            k_in_avail_d = 1'b0;
          end
        end
      end

      DONE: begin
        state_d      = IDLE;
        k_in_avail_d = 1'b0;
      end

      default: begin
        state_d      = IDLE;
        k_in_avail_d = 1'b0;
      end
    endcase
  end

  // State register; a low reset clears control, counters, results and the outgoing word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      num_words_q  <= '0;
      seed_q       <= '0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      err_count_q  <= '0;
      first_err_q  <= '0;
      k_in_avail_q <= 1'b0;
      k_in_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      num_words_q  <= num_words_d;
      seed_q       <= seed_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      err_count_q  <= err_count_d;
      first_err_q  <= first_err_d;
      k_in_avail_q <= k_in_avail_d;
      k_in_data_q  <= k_in_data_d;
    end
  end

  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_q;
  assign k_in_avail    = k_in_avail_q;
  assign k_in_data     = k_in_data_q;
  assign k_out_ready   = rx_ready;

endmodule

// File: tb/tb_toy_stream_checker.sv
// Bench for toy_stream_checker: a behavioural "+1 per lane" kernel with optional stalls and
// injected lane corruption, a per-cycle monitor, and scripted plus randomized runs.
module tb_toy_stream_checker;

  localparam int DW = 512;
  localparam int CW = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_words;
  logic [31:0]   seed;
  logic          busy;
  logic          done;
  logic [CW-1:0] err_count;
  logic [CW-1:0] first_err_idx;
  logic          k_in_avail;
  logic          k_in_ready;
  logic [DW-1:0] k_in_data;
  logic          k_out_avail;
  logic          k_out_ready;
  logic [DW-1:0] k_out_data;

  toy_stream_checker #(.C_DATA_WIDTH(DW), .C_COUNT_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_words    (num_words),
    .seed         (seed),
    .busy         (busy),
    .done         (done),
    .err_count    (err_count),
    .first_err_idx(first_err_idx),
    .k_in_avail   (k_in_avail),
    .k_in_ready   (k_in_ready),
    .k_in_data    (k_in_data),
    .k_out_avail  (k_out_avail),
    .k_out_ready  (k_out_ready),
    .k_out_data   (k_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        gate;
  logic        mon_en;
  logic [31:0] cur_seed;
  int          cur_nw;
  int          tx_n;
  int          rx_n;
  int          done_pulses;
  logic        done_prev;
  logic        hold_pending;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] sent_w0, sent_w1, recv_w0;
  bit          corrupt [64];
  int          corrupt_lane [64];
  logic [31:0] widx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference word: lane i of word n = s + 16n + i (+1), each lane wrapping independently.
  function automatic logic [DW-1:0] pat(input logic [31:0] s, input int n, input bit p1);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = s + 32'(n * 16) + 32'(i) + {31'd0, p1};
    return w;
  endfunction

  // Kernel model: out = in + 1 per lane, ready follows out_ready, both gated by a stall signal.
  always_comb begin
    k_in_ready  = k_out_ready & gate;
    k_out_avail = k_in_avail & gate;
    widx        = (k_in_data[31:0] - cur_seed) >> 4;
    k_out_data  = '0;
    for (int i = 0; i < 16; i++) k_out_data[i*32 +: 32] = k_in_data[i*32 +: 32] + 32'd1;
    if (widx < 32'd64 && corrupt[widx[5:0]])
      k_out_data[corrupt_lane[widx[5:0]] * 32] = ~k_out_data[corrupt_lane[widx[5:0]] * 32];
  end

  // Per-cycle monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (k_in_avail && k_in_ready) begin
        chk("tx_bound", 32'(tx_n < cur_nw), 32'd1);
        chkw("tx_word", k_in_data, pat(cur_seed, tx_n, 1'b0));
        if (tx_n == 0) sent_w0 = k_in_data;
        if (tx_n == 1) sent_w1 = k_in_data;
        tx_n++;
      end
      if (hold_pending && k_in_avail) chkw("tx_hold", k_in_data, hold_data);
      hold_pending = k_in_avail && !k_in_ready;
      hold_data    = k_in_data;
      chk("rx_ready", 32'(k_out_ready), 32'(busy && rx_n < cur_nw));
      if (!busy) chk("idle_avail", 32'(k_in_avail), 32'd0);
      if (k_out_avail && k_out_ready) begin
        if (rx_n == 0) recv_w0 = k_out_data;
        rx_n++;
      end
      if (done) begin
        done_pulses++;
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_single", 32'(done_prev), 32'd0);
      end
      done_prev = done;
    end
  end

  task automatic clear_corrupt();
    for (int k = 0; k < 64; k++) begin
      corrupt[k]      = 1'b0;
      corrupt_lane[k] = 0;
    end
  endtask

  // One complete run; entered and left just after a rising edge.
  task automatic run_test(input logic [31:0] s, input int nw, input int gmode, input bit restart_mid);
    int exp_err;
    int exp_first;
    int cyc;
    exp_err   = 0;
    exp_first = -1;
    for (int k = 0; k < nw; k++) begin
      if (corrupt[k]) begin
        exp_err++;
        if (exp_first < 0) exp_first = k;
      end
    end
    cur_seed     = s;
    cur_nw       = nw;
    tx_n         = 0;
    rx_n         = 0;
    hold_pending = 1'b0;
    start        = 1'b1;
    num_words    = 32'(nw);
    seed         = s;
    gate         = 1'b0;
    @(posedge clk) #1;
    start     = 1'b0;
    num_words = $urandom;
    seed      = $urandom;
    chk("start_busy", 32'(busy), 32'(nw != 0));
    chk("start_done", 32'(done), 32'(nw == 0));
    chk("start_avail", 32'(k_in_avail), 32'(nw != 0));
    chk("start_ready", 32'(k_out_ready), 32'(nw != 0));
    if (nw != 0) chkw("start_word", k_in_data, pat(s, 0, 1'b0));
    cyc = 0;
    while (!done && cyc < 500) begin
      case (gmode)
        0:       gate = 1'b1;
        1:       gate = (cyc % 3 == 2);
        default: gate = 1'($urandom_range(0, 1));
      endcase
      if (restart_mid) begin
        if (cyc == 2) begin
          start     = 1'b1;
          num_words = 32'd1;
        end else begin
          start = 1'b0;
        end
      end
      @(posedge clk) #1;
      cyc++;
    end
    start = 1'b0;
    gate  = 1'b0;
    chk("done_reached", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("err_count", err_count, 32'(exp_err));
    if (exp_err != 0) chk("first_err_idx", first_err_idx, 32'(exp_first));
    chk("tx_total", 32'(tx_n), 32'(nw));
    chk("rx_total", 32'(rx_n), 32'(nw));
    @(posedge clk) #1;
    chk("done_width", 32'(done), 32'd0);
    chk("err_hold", err_count, 32'(exp_err));
    chk("post_avail", 32'(k_in_avail), 32'd0);
  endtask

  initial begin
    int cyc;
    int dp;
    reset     = 1'b0;
    start     = 1'b0;
    num_words = '0;
    seed      = '0;
    gate      = 1'b0;
    mon_en    = 1'b0;
    cur_seed  = '0;
    cur_nw    = 0;
    tx_n      = 0;
    rx_n      = 0;
    done_pulses  = 0;
    done_prev    = 1'b0;
    hold_pending = 1'b0;
    hold_data    = '0;
    sent_w0 = '0;
    sent_w1 = '0;
    recv_w0 = '0;
    clear_corrupt();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_avail", 32'(k_in_avail), 32'd0);
    chk("rst_ready", 32'(k_out_ready), 32'd0);
    chkw("rst_data", k_in_data, '0);
    chk("rst_err", err_count, 32'd0);
    chk("rst_first", first_err_idx, 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk) #1;

    // Plain loopback from seed 0.
    run_test(32'd0, 4, 0, 1'b0);
    chk("w1_lane0", sent_w1[31:0], 32'h10);
    chk("w1_lane15", sent_w1[511:480], 32'h1f);

    // Lane wrap with no carry between lanes.
    run_test(32'hFFFF_FFFF, 1, 0, 1'b0);
    chk("wrap_tx_l0", sent_w0[31:0], 32'hFFFF_FFFF);
    chk("wrap_tx_l1", sent_w0[63:32], 32'h0000_0000);
    chk("wrap_rx_l0", recv_w0[31:0], 32'h0000_0000);
    chk("wrap_rx_l1", recv_w0[63:32], 32'h0000_0001);

    // Kernel ready one cycle in three.
    run_test(32'h0000_1000, 8, 1, 1'b0);

    // Corrupted words 2 and 5.
    corrupt[2] = 1'b1; corrupt_lane[2] = 3;
    corrupt[5] = 1'b1; corrupt_lane[5] = 3;
    run_test(32'h0000_1234, 8, 0, 1'b0);
    chk("inj_err_count", err_count, 32'd2);
    chk("inj_first_idx", first_err_idx, 32'd2);
    clear_corrupt();

    // Empty run, then a start pulse during RUN that must be ignored.
    run_test(32'h5555_0000, 0, 0, 1'b0);
    chk("zero_tx", 32'(tx_n), 32'd0);
    run_test(32'h7000_0000, 6, 1, 1'b1);

    // Mid-run reset aborts and clears partial results.
    corrupt[0] = 1'b1; corrupt_lane[0] = 5;
    cur_seed  = 32'hA5A5_0000;
    cur_nw    = 10;
    tx_n      = 0;
    rx_n      = 0;
    start     = 1'b1;
    num_words = 32'd10;
    seed      = cur_seed;
    gate      = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    cyc   = 0;
    while (tx_n < 3 && cyc < 100) begin
      @(posedge clk) #1;
      cyc++;
    end
    chk("pre_rst_progress", 32'(tx_n >= 3), 32'd1);
    chk("pre_rst_err", err_count, 32'd1);
    dp    = done_pulses;
    reset = 1'b0;
    @(posedge clk) #1;
    reset = 1'b1;
    gate  = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_avail", 32'(k_in_avail), 32'd0);
    chk("abort_ready", 32'(k_out_ready), 32'd0);
    chkw("abort_data", k_in_data, '0);
    chk("abort_err", err_count, 32'd0);
    chk("abort_first", first_err_idx, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_pulses), 32'(dp));
    clear_corrupt();
    run_test(32'h0BAD_F00D, 2, 0, 1'b0);

    // Randomized runs with random stalls and random lane corruption.
    for (int r = 0; r < 6; r++) begin
      logic [31:0] rs;
      int          rn;
      rs = $urandom;
      rn = $urandom_range(1, 20);
      clear_corrupt();
      for (int k = 0; k < rn; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          corrupt[k]      = 1'b1;
          corrupt_lane[k] = $urandom_range(0, 15);
        end
      end
      run_test(rs, rn, 2, 1'b0);
    end
    clear_corrupt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toy_stream_checker.md
# toy_stream_checker

Self-checking traffic driver for the kernel streaming interface. It sources a deterministic word stream into a kernel's input port (avail/ready/data), sinks the kernel's output stream, and checks every output lane against the expected "input plus one" result. It sits opposite the toy kernel as the other end of both of its stream ports, and is used for on-FPGA loopback bring-up and in simulation benches.

## Interface
- C_DATA_WIDTH, 512, stream word width; multiple of 32; L = C_DATA_WIDTH/32 lanes.
- C_COUNT_WIDTH, 32, width of word counters and error counters.

- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_words  in  C_COUNT_WIDTH  words to send/check; latched on start.
- seed  in  32  pattern base; latched on start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of run.
- err_count  out  C_COUNT_WIDTH  mismatched words this run, saturating.
- first_err_idx  out  C_COUNT_WIDTH  index of first mismatched word; valid when err_count != 0.
- k_in_avail  out  1  word valid toward the kernel input.
- k_in_ready  in  1  kernel accepts the word.
- k_in_data  out  C_DATA_WIDTH  word toward the kernel.
- k_out_avail  in  1  kernel output valid.
- k_out_ready  out  1  checker accepts the kernel output.
- k_out_data  in  C_DATA_WIDTH  kernel output word.

## Operation
- Pattern: word n, lane i (bits i*32 +: 32) = seed + n*L + i, mod 2^32. Expected output lane = pattern + 1, mod 2^32.
- FSM states:
  - IDLE: start=1 latches num_words and seed, clears tx_cnt, rx_cnt, err_count and first_err_idx, then moves to RUN. If num_words=0, it moves to DONE instead.
  - RUN: transmit and receive proceed independently. When rx_cnt reaches num_words, the FSM moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Transmit:
  - k_in_avail and k_in_data are registered.
  - A transfer occurs when k_in_avail && k_in_ready; tx_cnt then increments and the next word loads in the same edge.
  - While k_in_avail=1 and k_in_ready=0, k_in_data is held stable.
  - k_in_avail drops after word num_words-1 is accepted.
- Receive:
  - k_out_ready=1 only in RUN with rx_cnt < num_words.
  - On k_out_avail && k_out_ready, all L lanes are compared against the expected word for rx_cnt.
  - Any lane mismatch increments err_count by 1 per word, saturating at all-ones.
  - The first mismatch latches first_err_idx = rx_cnt.
  - rx_cnt increments on every accepted word.
- Results: err_count and first_err_idx hold after DONE until the next start.
- start asserted in RUN or DONE is ignored.
- Output beats received while k_out_ready=0 are not consumed. This is the kernel's responsibility under the handshake.

## Timing
- Reset (reset=0 at an edge): FSM in IDLE, busy=0, done=0, k_in_avail=0, k_in_data=0, k_out_ready=0, err_count=0, first_err_idx=0, all counters 0.
- A reset mid-run aborts immediately: no done pulse, and any partial results are cleared.
- Start latency:
  - Edge sampling start (num_words>0): next cycle busy=1, k_in_avail=1, k_in_data=word 0, k_out_ready=1.
  - num_words=0: next cycle done=1, busy=0, and k_in_avail never rises.
- Throughput: one word per cycle in each direction when ready/avail are continuously high.
- End of run: done=1 in the cycle after the edge that accepts the last output word. busy=0 in that same cycle. err_count already includes the last word.
- Simultaneous send and receive in one cycle is normal. The counters are independent.
- Lane arithmetic is 32-bit wrapping with no carry between lanes. n*L is computed in C_COUNT_WIDTH bits, then truncated to 32.

## Structure
- Package toy_stream_pkg:
  - LANE_W=32.
  - State enum {IDLE, RUN, DONE}.
  - Function lane_count(C_DATA_WIDTH).
- Sub-module toy_lane_pattern (parameter C_DATA_WIDTH):
  - Combinational; inputs seed, index, add_one.
  - Output is the full word.
  - Instantiated twice: once for the tx word (add_one=0) and once for the expected word (add_one=1).
- Top level holds the FSM, counters, tx registers, and compare/error logic.

## Test plan
- Wrapping kernel (out = in + 1 per lane, in_ready = out_ready), num_words=4, seed=0 -> 4 tx and 4 rx handshakes; word 1 lane 0 sent = 0x10 (L=16); done pulse; err_count=0.
- seed=0xFFFFFFFF, num_words=1 -> lane 0 sent 0xFFFFFFFF and received 0x00000000; lane 1 sent 0x00000000; err_count=0 (wrap, no cross-lane carry).
- k_in_ready high one cycle in three, num_words=8 -> k_in_data stable across stalled cycles; exactly 8 transfers; err_count=0.
- Kernel flips bit 0 of lane 3 on word 2 and word 5, num_words=8 -> err_count=2, first_err_idx=2.
- num_words=0 -> done=1 on the cycle after start; k_in_avail stays 0; start during RUN ignored in a separate run.
- reset=0 for one cycle mid-run (after 3 of 10 words) -> all outputs at reset values with no done pulse; a following start with num_words=2 completes with err_count=0.
